// File: rtl/surfturf_cmd_framer.sv
// SURF command framer: packs run command, trigger and firmware bytes
// into one 32-bit command word per fixed-length sysclk frame.
module surfturf_cmd_framer #(
    parameter int FRAME_LEN   = 8,
    parameter int RUNCMD_BITS = 2,
    parameter int TRIG_BITS   = 15
) (
    input  logic                   sysclk_i,
    input  logic                   sysclk_rstn_i,
    input  logic                   fw_en_i,
    input  logic [RUNCMD_BITS-1:0] runcmd_tdata,
    input  logic                   runcmd_tvalid,
    output logic                   runcmd_tready,
    input  logic [TRIG_BITS-1:0]   trig_tdata,
    input  logic                   trig_tvalid,
    output logic                   trig_tready,
    input  logic [7:0]             fw_tdata,
    input  logic                   fw_tvalid,
    output logic                   fw_tready,
    output logic [31:0]            cmd_o,
    output logic                   cmd_valid_o,
    output logic [11:0]            fw_count_o
);

    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [4:0]    seq_q, seq_d;
    logic [31:0]   cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [11:0]   fw_count_q, fw_count_d;

    logic cap;
    logic rc_xfer;
    logic trig_xfer;
    logic fw_xfer;

    // Gating with reset keeps every tready low while reset is held.
    assign cap           = sysclk_rstn_i && (phase_q == LAST);
    assign runcmd_tready = cap;
    assign trig_tready   = cap;
    assign fw_tready     = cap && fw_en_i;

    assign rc_xfer   = runcmd_tvalid && runcmd_tready;
    assign trig_xfer = trig_tvalid && trig_tready;
    assign fw_xfer   = fw_tvalid && fw_tready;

    always_comb begin
        phase_d     = cap ? '0 : phase_q + PW'(1);
        seq_d       = seq_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cap;
        fw_count_d  = fw_count_q;
        if (cap) begin
            cmd_d = {rc_xfer ? runcmd_tdata : '0,
                     trig_xfer,
                     trig_xfer ? trig_tdata : '0,
                     fw_xfer,
                     fw_xfer ? fw_tdata : 8'h00,
                     seq_q};
            seq_d = seq_q + 5'd1;
        end
        if (fw_xfer) begin
            fw_count_d = fw_count_q + 12'd1;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            phase_q     <= '0;
            seq_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            fw_count_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            seq_q       <= seq_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            fw_count_q  <= fw_count_d;
        end
    end

    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign fw_count_o  = fw_count_q;

endmodule

// File: tb/tb_surfturf_cmd_framer.sv
// Self-checking bench for surfturf_cmd_framer: scenario tasks compared
// against a frame-level behavioural model of the command word.
module tb_surfturf_cmd_framer;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fw_en = 1'b0;
    logic [1:0]  rc_d = '0;
    logic        rc_v = 1'b0;
    logic        rc_r;
    logic [14:0] tr_d = '0;
    logic        tr_v = 1'b0;
    logic        tr_r;
    logic [7:0]  fw_d = '0;
    logic        fw_v = 1'b0;
    logic        fw_r;
    logic [31:0] cmd_o;
    logic        cmd_valid_o;
    logic [11:0] fw_count_o;

    int checks = 0;
    int fails  = 0;

    surfturf_cmd_framer #(
        .FRAME_LEN(FL), .RUNCMD_BITS(2), .TRIG_BITS(15)
    ) dut (
        .sysclk_i(clk),
        .sysclk_rstn_i(rstn),
        .fw_en_i(fw_en),
        .runcmd_tdata(rc_d),
        .runcmd_tvalid(rc_v),
        .runcmd_tready(rc_r),
        .trig_tdata(tr_d),
        .trig_tvalid(tr_v),
        .trig_tready(tr_r),
        .fw_tdata(fw_d),
        .fw_tvalid(fw_v),
        .fw_tready(fw_r),
        .cmd_o(cmd_o),
        .cmd_valid_o(cmd_valid_o),
        .fw_count_o(fw_count_o)
    );

    always #5 clk = ~clk;

    // Frame-level reference: edges since reset, one word per FL edges.
    int          m_cnt = 0;
    int          m_seq = 0;
    int          m_fwc = 0;
    logic [31:0] m_cmd = '0;
    logic        m_cv = 1'b0;
    logic        m_rc_x = 1'b0;
    logic        m_tr_x = 1'b0;
    logic        m_fw_x = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_cnt = 0; m_seq = 0; m_fwc = 0;
            m_cmd = '0; m_cv = 1'b0;
            m_rc_x = 1'b0; m_tr_x = 1'b0; m_fw_x = 1'b0;
        end else begin
            m_cv = 1'b0;
            m_rc_x = 1'b0; m_tr_x = 1'b0; m_fw_x = 1'b0;
            if (m_cnt % FL == FL - 1) begin
                m_rc_x = rc_v;
                m_tr_x = tr_v;
                m_fw_x = fw_v && fw_en;
                m_cmd = 32'(m_seq);
                if (m_rc_x) m_cmd = m_cmd | (32'(rc_d) << 30);
                if (m_tr_x) m_cmd = m_cmd | (32'h1 << 29) | (32'(tr_d) << 14);
                if (m_fw_x) m_cmd = m_cmd | (32'h1 << 13) | (32'(fw_d) << 5);
                m_cv = 1'b1;
                m_seq = (m_seq + 1) % 32;
                if (m_fw_x) m_fwc = (m_fwc + 1) % 4096;
            end
            m_cnt++;
        end
    end

    function automatic logic exp_cap();
        return rstn && (m_cnt % FL == FL - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        rc_v = 1'b0; tr_v = 1'b0; fw_v = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        fw_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cmd_o !== 32'h0 || cmd_valid_o !== 1'b0 || fw_count_o !== 12'h0) begin
                fails++;
                $display("FAIL reset_out cmd=%h v=%b cnt=%h exp 0/0/0", cmd_o, cmd_valid_o, fw_count_o);
            end
            checks++;
            if ({rc_r, tr_r, fw_r} !== 3'b000) begin
                fails++;
                $display("FAIL reset_tready got=%b exp=000", {rc_r, tr_r, fw_r});
            end
        end
    endtask

    task automatic test_idle();
        rstn = 1'b1;
        for (int c = 1; c <= 3 * FL; c++) begin
            tick();
            checks++;
            if (cmd_valid_o !== (c % FL == 0)) begin
                fails++;
                $display("FAIL idle_strobe c=%0d got=%b exp=%b", c, cmd_valid_o, (c % FL == 0));
            end
            if (c % FL == 0) begin
                checks++;
                if (cmd_o !== 32'(c / FL - 1)) begin
                    fails++;
                    $display("FAIL idle_word c=%0d got=%h exp=%h", c, cmd_o, 32'(c / FL - 1));
                end
            end
        end
    endtask

    task automatic test_runcmd();
        bit done = 0;
        for (int i = 0; i < FL && (m_cnt % FL != 3); i++) tick();
        rc_v = 1'b1;
        rc_d = 2'b10;
        #1;
        for (int i = 0; i < 2 * FL && !done; i++) begin
            checks++;
            if (rc_r !== exp_cap()) begin
                fails++;
                $display("FAIL runcmd_tready got=%b exp=%b", rc_r, exp_cap());
            end
            tick();
            if (m_rc_x) begin
                rc_v = 1'b0;
                done = 1;
            end
        end
        checks++;
        if (!done || cmd_valid_o !== 1'b1 || cmd_o[31:30] !== 2'b10 || cmd_o !== m_cmd) begin
            fails++;
            $display("FAIL runcmd_word got=%h v=%b exp=%h", cmd_o, cmd_valid_o, m_cmd);
        end
        repeat (FL) tick();
        checks++;
        if (cmd_valid_o !== 1'b1 || cmd_o[31:30] !== 2'b00) begin
            fails++;
            $display("FAIL runcmd_nop got=%h v=%b exp_runcmd=00", cmd_o, cmd_valid_o);
        end
    endtask

    task automatic test_all_streams();
        logic [31:0] exp;
        bit done = 0;
        rc_d = 2'b01; tr_d = 15'h1234; fw_d = 8'hA5;
        rc_v = 1'b1; tr_v = 1'b1; fw_v = 1'b1;
        fw_en = 1'b1;
        for (int i = 0; i < 2 * FL && !done; i++) begin
            tick();
            done = m_cv;
        end
        rc_v = 1'b0; tr_v = 1'b0; fw_v = 1'b0;
        exp = (32'h1 << 30) | (32'h1 << 29) | (32'h1234 << 14)
            | (32'h1 << 13) | (32'hA5 << 5) | 32'((m_seq + 31) % 32);
        checks++;
        if (!done || cmd_o !== exp) begin
            fails++;
            $display("FAIL all_word got=%h exp=%h", cmd_o, exp);
        end
        checks++;
        if (fw_count_o !== 12'd1) begin
            fails++;
            $display("FAIL all_fwcount got=%0d exp=1", fw_count_o);
        end
    endtask

    task automatic test_fw_disable();
        logic [7:0] sent;
        int n = 0;
        fw_en = 1'b0;
        fw_v = 1'b1;
        fw_d = 8'($urandom);
        #1;
        for (int i = 0; i < 5 * FL; i++) begin
            checks++;
            if (fw_r !== 1'b0) begin
                fails++;
                $display("FAIL fwdis_tready got=%b exp=0", fw_r);
            end
            tick();
            if (m_cv) begin
                checks++;
                if (cmd_o[13:5] !== 9'h0) begin
                    fails++;
                    $display("FAIL fwdis_field got=%h exp=0", cmd_o[13:5]);
                end
            end
        end
        checks++;
        if (fw_count_o !== 12'd1) begin
            fails++;
            $display("FAIL fwdis_count got=%0d exp=1", fw_count_o);
        end
        fw_en = 1'b1;
        for (int i = 0; i < 5 * FL && n < 3; i++) begin
            sent = fw_d;
            tick();
            if (m_fw_x) begin
                n++;
                checks++;
                if (cmd_o[13] !== 1'b1 || cmd_o[12:5] !== sent) begin
                    fails++;
                    $display("FAIL fwdrain_byte got=%h exp=1_%h", cmd_o[13:5], sent);
                end
                fw_d = 8'($urandom);
            end
        end
        fw_v = 1'b0;
        checks++;
        if (n != 3 || fw_count_o !== 12'd4) begin
            fails++;
            $display("FAIL fwdrain_count got=%0d n=%0d exp=4", fw_count_o, n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 50 * FL; i++) begin
            tick();
            if (m_rc_x) rc_v = 1'b0;
            if (m_tr_x) tr_v = 1'b0;
            if (m_fw_x) fw_v = 1'b0;
            if (!rc_v && $urandom_range(2) == 0) begin
                rc_v = 1'b1; rc_d = 2'($urandom);
            end
            if (!tr_v && $urandom_range(2) == 0) begin
                tr_v = 1'b1; tr_d = 15'($urandom);
            end
            if (!fw_v && $urandom_range(1) == 0) begin
                fw_v = 1'b1; fw_d = 8'($urandom);
            end
            fw_en = ($urandom_range(3) != 0);
            #1;
            checks++;
            if (cmd_o !== m_cmd || cmd_valid_o !== m_cv || fw_count_o !== 12'(m_fwc)) begin
                fails++;
                $display("FAIL rand_out cmd=%h v=%b cnt=%0d exp %h/%b/%0d",
                         cmd_o, cmd_valid_o, fw_count_o, m_cmd, m_cv, m_fwc);
            end
            checks++;
            if ({rc_r, tr_r, fw_r} !== {exp_cap(), exp_cap(), exp_cap() && fw_en}) begin
                fails++;
                $display("FAIL rand_tready got=%b exp=%b", {rc_r, tr_r, fw_r},
                         {exp_cap(), exp_cap(), exp_cap() && fw_en});
            end
        end
        rc_v = 1'b0; tr_v = 1'b0; fw_v = 1'b0;
    endtask

    task automatic test_fw_wrap();
        int n = 0;
        int frames = 0;
        reset_dut();
        fw_en = 1'b1;
        fw_v = 1'b1;
        fw_d = 8'($urandom);
        for (int i = 0; i < 4100 * FL && n < 4097; i++) begin
            tick();
            if (m_fw_x) begin
                n++;
                fw_d = 8'($urandom);
                if (n == 4096) begin
                    checks++;
                    if (fw_count_o !== 12'd0) begin
                        fails++;
                        $display("FAIL fwwrap_zero got=%0d exp=0", fw_count_o);
                    end
                end
            end
            if (m_cv) begin
                checks++;
                if (cmd_valid_o !== 1'b1 || cmd_o[4:0] !== 5'(frames % 32)) begin
                    fails++;
                    $display("FAIL fwwrap_seq got=%0d v=%b exp=%0d", cmd_o[4:0], cmd_valid_o, frames % 32);
                end
                frames++;
            end
        end
        fw_v = 1'b0;
        checks++;
        if (n != 4097 || fw_count_o !== 12'd1) begin
            fails++;
            $display("FAIL fwwrap_end got=%0d n=%0d exp=1", fw_count_o, n);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < FL && (m_cnt % FL != 3); i++) tick();
        rstn = 1'b0;
        fw_en = 1'b1;
        rc_v = 1'b1;
        rc_d = 2'b11;
        #1;
        checks++;
        if ({rc_r, tr_r, fw_r} !== 3'b000) begin
            fails++;
            $display("FAIL rstmid_tready got=%b exp=000", {rc_r, tr_r, fw_r});
        end
        repeat (2) tick();
        checks++;
        if (cmd_o !== 32'h0 || cmd_valid_o !== 1'b0 || rc_r !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_hold cmd=%h v=%b r=%b exp 0", cmd_o, cmd_valid_o, rc_r);
        end
        rstn = 1'b1;
        #1;
        for (int c = 1; c <= FL; c++) begin
            tick();
            if (c < FL) begin
                checks++;
                if (rc_r !== (c == FL - 1)) begin
                    fails++;
                    $display("FAIL rstmid_cap c=%0d got=%b exp=%b", c, rc_r, (c == FL - 1));
                end
            end else begin
                checks++;
                if (cmd_valid_o !== 1'b1 || cmd_o !== 32'hC000_0000) begin
                    fails++;
                    $display("FAIL rstmid_word got=%h v=%b exp=c0000000", cmd_o, cmd_valid_o);
                end
            end
        end
        rc_v = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_runcmd();
        test_all_streams();
        test_fw_disable();
        test_random();
        test_fw_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/surfturf_cmd_framer.md
Name: surfturf_cmd_framer

Overview:
- Downstream of the TURFIO SURF-link register/FIFO stage, in the sysclk domain.
- Consumes three AXI4-Stream sources: run command (2 bits), trigger (15 bits) and firmware-update bytes (8 bits).
- Packs them into one 32-bit command word per fixed-length frame.
- The link serializer presents that word to the SURFs.

Parameters:
- FRAME_LEN, 8: sysclk cycles per command frame; legal range 4..64.
- RUNCMD_BITS, 2: run command width; must equal the rackbus run command width.
- TRIG_BITS, 15: trigger width; must equal the rackbus trigger width.

Ports:
- sysclk_i  in  1  system clock; all logic is in this domain.
- sysclk_rstn_i  in  1  synchronous, active-low reset.
- fw_en_i  in  1  allows firmware bytes to be consumed; sampled every cycle.
- runcmd_tdata  in  RUNCMD_BITS  run command.
- runcmd_tvalid  in  1  run command valid.
- runcmd_tready  out  1  run command accept.
- trig_tdata  in  TRIG_BITS  trigger word.
- trig_tvalid  in  1  trigger valid.
- trig_tready  out  1  trigger accept.
- fw_tdata  in  8  firmware-update byte.
- fw_tvalid  in  1  firmware byte valid.
- fw_tready  out  1  firmware byte accept.
- cmd_o  out  32  current command word.
- cmd_valid_o  out  1  one-cycle strobe: cmd_o changed (frame start).
- fw_count_o  out  12  firmware bytes sent, modulo 4096.

Behaviour:
- Reset (sysclk_rstn_i low at a clock edge):
  - phase=0, seq=0, cmd_o=0, cmd_valid_o=0, fw_count_o=0.
  - All treadys are 0 while reset is held.
  - Reset mid-frame abandons the frame; nothing captured in that frame is emitted.
- Phase counter:
  - Runs 0..FRAME_LEN-1 and wraps to 0.
  - Phase FRAME_LEN-1 is the capture cycle.
- Handshake:
  - runcmd_tready and trig_tready are 1 only on the capture cycle.
  - fw_tready = (capture cycle && fw_en_i).
  - A beat transfers only when tvalid && tready on the same edge.
  - At most one beat per stream per frame.
  - tvalid asserted off the capture cycle is ignored until the next capture cycle; the source holds it.
- Word assembly: registered at the edge ending the capture cycle.
  - [31:30] runcmd: tdata if transferred, else 2'b00 (NOP).
  - [29] trig_valid; [28:14] trigger: tdata if transferred, else 0.
  - [13] fw_valid; [12:5] fw byte: tdata if transferred, else 0.
  - [4:0] seq: value before increment.
  - seq increments by 1 every frame, wrapping 31->0.
- Output timing:
  - cmd_o updates, and cmd_valid_o=1, on the cycle phase returns to 0.
  - Latency: a transfer on the capture cycle appears on cmd_o 1 cycle later.
  - cmd_o holds for the remaining FRAME_LEN-1 cycles.
  - Idle frames (no transfers) are still emitted, with all valid fields 0 and seq incrementing.
- fw_count_o increments on each fw transfer and wraps 4095->0 (1024 32-bit words = 4096 bytes).
- fw_en_i low: fw_tready=0, fw fields 0, fw_count_o unchanged. Pending fw data remains in the source.
- Simultaneous events: all three streams may transfer in the same capture cycle; all land in the same word, with no priority.
- The first frame after reset is emitted FRAME_LEN cycles after release, with seq=0.

Test Plan:
- Reset release, all tvalid=0, FRAME_LEN=8 -> cmd_valid_o pulses at cycles 8,16,24...; cmd_o = 0x00000000, 0x00000001, 0x00000002 (seq only).
- runcmd_tvalid=1, tdata=2'b10, raised mid-frame -> runcmd_tready high only on the capture cycle; next word bits[31:30]=10; tvalid dropped by source; following word has [31:30]=00.
- trig_tdata=15'h1234, runcmd=2'b01, fw byte 0xA5 all valid, fw_en_i=1 -> one word with [31:30]=01, [29]=1, [28:14]=0x1234, [13]=1, [12:5]=0xA5; fw_count_o=1.
- fw_en_i=0 with fw_tvalid=1 for 5 frames -> fw_tready never 1, fw_count_o stays 0; set fw_en_i=1 -> bytes drain one per frame.
- Stream 4097 fw bytes -> fw_count_o wraps to 0 after byte 4096 and reads 1 at the end; seq wraps 31->0 with no glitch.
- Assert reset at phase 3 with runcmd pending -> cmd_o=0 and treadys=0 during reset; after release the first capture is at cycle 7 and the pending runcmd appears in the seq=0 word.
